// File: rtl/lsu_wb_master.sv
// Load/store unit bus master: turns one RV32I load/store request into a single
// pipelined Wishbone B4 access. It aligns store data and byte selects,
// extracts and extends load data, and reports misaligned accesses, illegal
// funct3 values and bus timeouts as errors.
//
// Handshakes: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE. resp_valid is a one-cycle pulse; resp_err and
// resp_rd_data are meaningful only while it is high. On the bus, a strobe
// transfers on a rising edge where wb_stb && !wb_stall. wb_ack is sampled only
// while wb_cyc is high.
module lsu_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wr_data,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rd_data,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_wr_en,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_wr_data,
  output logic [3:0]  wb_wr_sel,
  input  logic        wb_ack,
  input  logic        wb_stall,
  input  logic [31:0] wb_rd_data,
  output logic [1:0]  dbg_state
);

  // Counter is at least 8 bits wide and wide enough to hold TIMEOUT_CYCLES.
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t           state, state_n;
  logic [2:0]       f3_q;
  logic [1:0]       lane_q;
  logic [CNT_W-1:0] cnt;

  logic             legal;
  logic [3:0]       sel_n;
  logic [31:0]      data_n;
  logic [31:0]      rd_shift;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_ext;
  logic             timeout;

  // Decode legality, byte selects and lane-replicated store data of the incoming request.
  always_comb begin
    legal  = 1'b0;
    sel_n  = 4'b1111;
    data_n = 32'd0;
    if (req_wr) begin
      case (req_funct3)
        3'b000: begin
          legal  = 1'b1;
          sel_n  = 4'b0001 << req_addr[1:0];
          data_n = {4{req_wr_data[7:0]}};
        end
        3'b001: begin
          legal  = ~req_addr[0];
          sel_n  = 4'b0011 << req_addr[1:0];
          data_n = {2{req_wr_data[15:0]}};
        end
        3'b010: begin
          legal  = (req_addr[1:0] == 2'b00);
          data_n = req_wr_data;
        end
        default: legal = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b100: legal = 1'b1;
        3'b001, 3'b101: legal = ~req_addr[0];
        3'b010:         legal = (req_addr[1:0] == 2'b00);
        default:        legal = 1'b0;
      endcase
    end
  end

  // Pick the addressed byte/halfword from the read bus and extend it per funct3.
  always_comb begin
    rd_shift = wb_rd_data >> {lane_q, 3'b000};
    rd_byte  = rd_shift[7:0];
    rd_half  = lane_q[1] ? wb_rd_data[31:16] : wb_rd_data[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_ext = {24'd0, rd_byte};
      3'b101:  load_ext = {16'd0, rd_half};
      default: load_ext = wb_rd_data;
    endcase
  end

  assign timeout = (cnt >= CNT_LAST);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    wb_cyc     = 1'b0;
    wb_stb     = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = legal ? S_REQ : S_RESP;
      end
      S_REQ: begin
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        if (wb_ack || timeout) state_n = S_RESP;
        else if (!wb_stall)    state_n = S_WAIT;
      end
      S_WAIT: begin
        wb_cyc = 1'b1;
        if (wb_ack || timeout) state_n = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign dbg_state = state;

  // Latch the bus request on acceptance, run the timeout counter, capture the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_wr_en     <= 1'b0;
      wb_addr      <= 32'd0;
      wb_wr_data   <= 32'd0;
      wb_wr_sel    <= 4'd0;
      f3_q         <= 3'd0;
      lane_q       <= 2'd0;
      cnt          <= '0;
      resp_err     <= 1'b0;
      resp_rd_data <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cnt          <= '0;
            resp_err     <= ~legal;
            resp_rd_data <= 32'd0;
            if (legal) begin
              wb_wr_en   <= req_wr;
              wb_addr    <= {req_addr[31:2], 2'b00};
              wb_wr_data <= data_n;
              wb_wr_sel  <= sel_n;
              f3_q       <= req_funct3;
              lane_q     <= req_addr[1:0];
            end
          end
        end
        S_REQ, S_WAIT: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (wb_ack) begin
            resp_err     <= 1'b0;
            resp_rd_data <= wb_wr_en ? 32'd0 : load_ext;
          end else if (timeout) begin
            resp_err     <= 1'b1;
            resp_rd_data <= 32'd0;
          end
        end
        S_RESP: begin
          resp_err     <= 1'b0;
          resp_rd_data <= 32'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_wb_master.sv
// Directed bench for lsu_wb_master: stores, loads with extension, stalled
// strobe, misaligned rejection, bus timeout and mid-transaction reset.
module tb_lsu_wb_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wr_data;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rd_data;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_wr_en;
  logic [31:0] wb_addr;
  logic [31:0] wb_wr_data;
  logic [3:0]  wb_wr_sel;
  logic        wb_ack;
  logic        wb_stall;
  logic [31:0] wb_rd_data;
  logic [1:0]  dbg_state;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  lsu_wb_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wr_data  (req_wr_data),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rd_data (resp_rd_data),
    .wb_cyc       (wb_cyc),
    .wb_stb       (wb_stb),
    .wb_wr_en     (wb_wr_en),
    .wb_addr      (wb_addr),
    .wb_wr_data   (wb_wr_data),
    .wb_wr_sel    (wb_wr_sel),
    .wb_ack       (wb_ack),
    .wb_stall     (wb_stall),
    .wb_rd_data   (wb_rd_data),
    .dbg_state    (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current (IDLE) cycle; returns in the cycle after acceptance.
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data);
    req_valid   = 1'b1;
    req_wr      = wr;
    req_funct3  = f3;
    req_addr    = addr;
    req_wr_data = data;
    #1;
    chk("req_ready_on_issue", req_ready, 1'b1);
    next_cycle();
    req_valid = 1'b0;
  endtask

  // Load with immediate ack; checks the bus phase and the extended result.
  task automatic load_ack(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rd, input logic [31:0] exp);
    exp_q.push_back(exp);
    issue(1'b0, f3, addr, 32'h0);
    chk({tag, "_stb"}, wb_stb, 1'b1);
    chk({tag, "_wr_en"}, wb_wr_en, 1'b0);
    chk({tag, "_addr"}, wb_addr, {addr[31:2], 2'b00});
    chk({tag, "_sel"}, wb_wr_sel, 4'b1111);
    chk({tag, "_wdata"}, wb_wr_data, 32'h0);
    wb_ack     = 1'b1;
    wb_rd_data = rd;
    next_cycle();
    wb_ack     = 1'b0;
    wb_rd_data = 32'h0;
    chk({tag, "_resp_valid"}, resp_valid, 1'b1);
    chk({tag, "_resp_err"}, resp_err, 1'b0);
    chk({tag, "_rd_data"}, resp_rd_data, exp_q.pop_front());
    next_cycle();
  endtask

  initial begin
    int acc;
    int n;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_wr      = 1'b0;
    req_funct3  = 3'd0;
    req_addr    = 32'd0;
    req_wr_data = 32'd0;
    wb_ack      = 1'b0;
    wb_stall    = 1'b0;
    wb_rd_data  = 32'd0;

    // Reset state
    #3;
    chk("rst_cyc", wb_cyc, 1'b0);
    chk("rst_stb", wb_stb, 1'b0);
    chk("rst_addr", wb_addr, 32'h0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    next_cycle();
    rst_n = 1'b1;

    // SW 0x40, immediate ack, minimum latency
    issue(1'b1, 3'b010, 32'h40, 32'hDEADBEEF);
    chk("sw_cyc", wb_cyc, 1'b1);
    chk("sw_stb", wb_stb, 1'b1);
    chk("sw_wr_en", wb_wr_en, 1'b1);
    chk("sw_addr", wb_addr, 32'h40);
    chk("sw_sel", wb_wr_sel, 4'b1111);
    chk("sw_wdata", wb_wr_data, 32'hDEADBEEF);
    chk("sw_no_resp_c1", resp_valid, 1'b0);
    wb_ack = 1'b1;
    next_cycle();
    wb_ack = 1'b0;
    chk("sw_resp_valid_c2", resp_valid, 1'b1);
    chk("sw_resp_err", resp_err, 1'b0);
    chk("sw_rd_data", resp_rd_data, 32'h0);
    chk("sw_cyc_dropped", wb_cyc, 1'b0);
    next_cycle();
    chk("sw_resp_one_cycle", resp_valid, 1'b0);

    // Loads with lane extraction and extension (back-to-back after RESP)
    load_ack("lb43", 3'b000, 32'h43, 32'h80FF1234, 32'hFFFFFF80);
    load_ack("lbu43", 3'b100, 32'h43, 32'h80FF1234, 32'h00000080);
    load_ack("lhu42", 3'b101, 32'h42, 32'h80FF1234, 32'h000080FF);
    load_ack("lh42", 3'b001, 32'h42, 32'h80FF1234, 32'hFFFF80FF);
    load_ack("lb41", 3'b000, 32'h41, 32'h80FF1234, 32'h00000012);
    load_ack("lw40", 3'b010, 32'h40, 32'h80FF1234, 32'h80FF1234);

    // SH 0x46 with 3 stall cycles: outputs held 4 cycles, single accepted stb
    issue(1'b1, 3'b001, 32'h46, 32'h0000ABCD);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      wb_stall = (i < 3);
      chk("sh_stb_held", wb_stb, 1'b1);
      chk("sh_sel_held", wb_wr_sel, 4'b1100);
      chk("sh_wdata_held", wb_wr_data, 32'hABCDABCD);
      chk("sh_addr_held", wb_addr, 32'h44);
      if (wb_stb && !wb_stall) acc++;
      next_cycle();
    end
    wb_stall = 1'b0;
    chk("sh_wait_stb", wb_stb, 1'b0);
    chk("sh_wait_cyc", wb_cyc, 1'b1);
    chk("sh_accepted_stb", acc, 1);
    wb_ack = 1'b1;
    next_cycle();
    wb_ack = 1'b0;
    chk("sh_resp_valid", resp_valid, 1'b1);
    chk("sh_resp_err", resp_err, 1'b0);
    next_cycle();

    // Misaligned LW 0x41: no bus cycle, error next cycle
    issue(1'b0, 3'b010, 32'h41, 32'h0);
    chk("lw41_no_cyc", wb_cyc, 1'b0);
    chk("lw41_resp_valid", resp_valid, 1'b1);
    chk("lw41_resp_err", resp_err, 1'b1);
    next_cycle();
    chk("lw41_no_cyc_after", wb_cyc, 1'b0);

    // Illegal store funct3 011
    issue(1'b1, 3'b011, 32'h40, 32'h0);
    chk("st011_no_cyc", wb_cyc, 1'b0);
    chk("st011_resp_err", resp_err, 1'b1);
    next_cycle();

    // Timeout: no ack, cyc held exactly 16 cycles then error response
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    n = 0;
    while (wb_cyc && n < 40) begin
      n++;
      next_cycle();
    end
    chk("to_cyc_cycles", n, 16);
    chk("to_resp_valid", resp_valid, 1'b1);
    chk("to_resp_err", resp_err, 1'b1);
    next_cycle();
    load_ack("after_to_lw", 3'b010, 32'h40, 32'h13572468, 32'h13572468);

    // Reset while in WAIT
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    next_cycle();
    chk("rw_in_wait_cyc", wb_cyc, 1'b1);
    chk("rw_in_wait_stb", wb_stb, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_async_cyc", wb_cyc, 1'b0);
    chk("rw_async_wr_en", wb_wr_en, 1'b0);
    chk("rw_async_addr", wb_addr, 32'h0);
    chk("rw_async_sel", wb_wr_sel, 4'h0);
    chk("rw_async_resp_valid", resp_valid, 1'b0);
    chk("rw_async_rd_data", resp_rd_data, 32'h0);
    next_cycle();
    chk("rw_hold_resp_valid", resp_valid, 1'b0);
    rst_n = 1'b1;
    issue(1'b1, 3'b000, 32'h51, 32'h0000005A);
    chk("sb51_stb", wb_stb, 1'b1);
    chk("sb51_sel", wb_wr_sel, 4'b0010);
    chk("sb51_wdata", wb_wr_data, 32'h5A5A5A5A);
    chk("sb51_addr", wb_addr, 32'h50);
    wb_ack = 1'b1;
    next_cycle();
    wb_ack = 1'b0;
    chk("sb51_resp_valid", resp_valid, 1'b1);
    chk("sb51_resp_err", resp_err, 1'b0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_wb_master.md
LSU_WB_MASTER -- requirements
Module: lsu_wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: bus cycles allowed from stb assertion to ack before abort.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port req_valid  in  1  pipeline load/store request.
REQ-005 SHALL have port req_ready  out  1  high when request accepted (IDLE state).
REQ-006 SHALL have port req_wr  in  1  1=store, 0=load.
REQ-007 SHALL have port req_funct3  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wr_data  in  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_err  out  1  valid with resp_valid; misaligned, illegal funct3 or timeout.
REQ-012 SHALL have port resp_rd_data  out  32  extended load result, valid with resp_valid.
REQ-013 SHALL have Wishbone initiator ports wb_cyc out 1, wb_stb out 1, wb_wr_en out 1, wb_addr out 32, wb_wr_data out 32, wb_wr_sel out 4, wb_ack in 1, wb_stall in 1, wb_rd_data in 32 (pipelined Wishbone B4).

Function
REQ-014 SHALL implement FSM states IDLE, REQ, WAIT, RESP; req_ready = (state==IDLE).
REQ-015 SHALL, in IDLE on req_valid with legal aligned access, latch request and enter REQ; next cycle wb_cyc=wb_stb=1 with registered address/data/sel/wr_en.
REQ-016 SHALL drive wb_addr = {req_addr[31:2],2'b00}.
REQ-017 SHALL drive wb_wr_sel: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; loads 4'b1111.
REQ-018 SHALL drive wb_wr_data: SB byte replicated x4; SH halfword replicated x2; SW unchanged; loads 0.
REQ-019 SHALL hold wb_stb and all wb_* outputs stable in REQ while wb_stall=1; on a cycle with wb_stall=0 transition to WAIT (wb_stb=0, wb_cyc=1).
REQ-020 SHALL accept wb_ack in REQ (same cycle as stall=0) or in WAIT; on sampled ack drop wb_cyc/wb_stb next cycle, enter RESP.
REQ-021 SHALL ignore wb_ack when wb_cyc=0.
REQ-022 SHALL, in RESP, assert resp_valid=1 for exactly one cycle, then return to IDLE; back-to-back request accepted the cycle after RESP.
REQ-023 SHALL extract load byte lane by addr[1:0]: LB/LBU byte at bits 8*addr[1:0]; LH/LHU halfword at bits 16*addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; stores return resp_rd_data=0.
REQ-024 SHALL flag misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; illegal funct3: load 011/110/111, store >=011.
REQ-025 SHALL, for misaligned/illegal requests, start no bus cycle (wb_cyc stays 0), go IDLE->RESP, and pulse resp_valid with resp_err=1 the next cycle.
REQ-026 SHALL count cycles in REQ/WAIT with 8+-bit saturating counter cleared on entry to REQ; when count reaches TIMEOUT_CYCLES without ack, drop wb_cyc/wb_stb next cycle, enter RESP with resp_err=1.
REQ-027 SHALL have minimum latency: request cycle 0, stb cycle 1, ack sampled end of cycle 1, resp_valid cycle 2.

Reset
REQ-028 SHALL, on rst_n=0, immediately force state IDLE, wb_cyc=wb_stb=wb_wr_en=0, wb_addr=wb_wr_data=0, wb_wr_sel=0, resp_valid=resp_err=0, resp_rd_data=0, counter=0.
REQ-029 SHALL, on reset mid-transaction, abandon the cycle with no resp_valid; first request after rst_n release accepted on the first rising edge with rst_n=1.

Verification
REQ-030 SHALL test SW addr 0x40 data 0xDEADBEEF, no stall, ack immediate -> wb_wr_sel=1111, wb_addr=0x40, resp_valid cycle 2, resp_err=0.
REQ-031 SHALL test LB addr 0x43, wb_rd_data 0x80FF_1234 -> resp_rd_data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x42 -> 0x000080FF.
REQ-032 SHALL test SH addr 0x46 data 0x0000ABCD with wb_stall=1 for 3 cycles -> wb_wr_sel=1100, wb_wr_data=0xABCDABCD held stable 4 cycles, single accepted stb.
REQ-033 SHALL test LW addr 0x41 -> wb_cyc never asserts, resp_valid next cycle with resp_err=1.
REQ-034 SHALL test load with wb_ack never asserted, TIMEOUT_CYCLES=16 -> wb_cyc drops after 16 cycles, resp_err=1, next request serviced normally.
REQ-035 SHALL test rst_n pulsed low while in WAIT -> all outputs 0 asynchronously, no resp_valid, subsequent SB addr 0x51 data 0x5A -> wb_wr_sel=0010, wb_wr_data=0x5A5A5A5A.
